// File: rtl/reg_file_if.sv
// Register-file access bus: two read ports and one write port.
interface reg_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] N1;
  logic [ADDR_W-1:0] N2;
  logic [ADDR_W-1:0] ND;
  logic [DATA_W-1:0] DI;
  logic              WE;
  logic [DATA_W-1:0] Q1;
  logic [DATA_W-1:0] Q2;

  modport master (output N1, output N2, output ND, output DI, output WE,
                  input  Q1, input  Q2);
  modport slave  (input  N1, input  N2, input  ND, input  DI, input  WE,
                  output Q1, output Q2);
endinterface

// File: rtl/reg_file.sv
// Two-read/one-write register file with hardwired-zero register 0.
// Optional write-through forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic       CLK,
  input  logic       CLRN,
  reg_file_if.slave  bus
);
  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q  [1:NREGS-1];
  logic [DATA_W-1:0] regs_d  [1:NREGS-1];
  logic [DATA_W-1:0] rd_view [NREGS];
  logic [DATA_W-1:0] q1_c;
  logic [DATA_W-1:0] q2_c;
  logic              wr_en_c;

  // A write is only live out of reset and to a non-zero destination.
  always_comb begin
    wr_en_c = CLRN && bus.WE && (bus.ND != '0);
  end

  always_comb begin
    for (int i = 1; i < int'(NREGS); i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en_c && (bus.ND == ADDR_W'(i))) begin
        regs_d[i] = bus.DI;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < int'(NREGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read view with register 0 tied to zero.
  always_comb begin
    rd_view[0] = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      rd_view[i] = regs_q[i];
    end
  end

  always_comb begin
    q1_c = rd_view[bus.N1];
    q2_c = rd_view[bus.N2];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en_c && (bus.N1 == bus.ND)) q1_c = bus.DI;
    if (wr_en_c && (bus.N2 == bus.ND)) q2_c = bus.DI;
`else
`endif
  end

  assign bus.Q1 = q1_c;
  assign bus.Q2 = q2_c;
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001: The block SHALL have parameter DATA_W, default 32, giving the register width in bits.
REQ-002: The block SHALL have parameter ADDR_W, default 5, giving the register-number width (2**ADDR_W registers).
REQ-003: The block SHALL have port CLK, input, 1 bit, the single clock, rising-edge active.
REQ-004: The block SHALL have port CLRN, input, 1 bit, asynchronous active-low reset.
REQ-005: The block SHALL have port N1, input, ADDR_W bits, read port 1 register number (rs, instr[25:21]).
REQ-006: The block SHALL have port N2, input, ADDR_W bits, read port 2 register number (rt, instr[20:16]).
REQ-007: The block SHALL have port ND, input, ADDR_W bits, write register number, driven by the rt/rd destination mux.
REQ-008: The block SHALL have port DI, input, DATA_W bits, write-back data.
REQ-009: The block SHALL have port WE, input, 1 bit, write enable (WREG from control).
REQ-010: The block SHALL have port Q1, output, DATA_W bits, read port 1 data.
REQ-011: The block SHALL have port Q2, output, DATA_W bits, read port 2 data.
REQ-012: Clocking and reset are fixed: one clock, CLK; reset CLRN is asynchronous and active-low.

Function
REQ-013: Storage SHALL be registers 1..(2**ADDR_W - 1), each DATA_W bits wide; register 0 has no storage.
REQ-014: Reads SHALL be combinational, meaning zero-cycle latency: Q1 = reg[N1] and Q2 = reg[N2].
REQ-015: A read of register 0 SHALL return all zeros on either port, in every configuration.
REQ-016: Write SHALL occur on the CLK rising edge when WE=1, CLRN=1 and ND!=0, storing DI into reg[ND]; write latency is one edge.
REQ-017: WE=1 with ND=0 SHALL cause no state change.
REQ-018: WE=0 SHALL leave all registers unchanged, whatever the values of ND and DI.
REQ-019: Only reg[ND] SHALL change on a write; all other registers hold.
REQ-020: Same-cycle read and write to one register (N1 or N2 equal to ND) SHALL return the pre-edge value, unless REQ-027 applies.
REQ-021: N1=N2 SHALL give identical Q1 and Q2.
REQ-022: No other state, counters or handshake; the block is always ready.

Reset
REQ-023: CLRN=0 SHALL asynchronously clear every register to 0, without waiting for CLK.
REQ-024: While CLRN=0, Q1 and Q2 SHALL read 0 for every address, and writes SHALL be ignored even on a clock edge.
REQ-025: CLRN asserted mid-operation SHALL discard any write on that edge, and register contents SHALL be 0 afterwards.
REQ-026: The first write after CLRN deasserts SHALL take effect on the next rising CLK edge.

Configuration
REQ-027: Macro REG_FILE_BYPASS_EN defined: a read SHALL return DI instead of the stored value when WE=1, CLRN=1, ND!=0 and the read number equals ND, on each port independently (write-through forwarding).
REQ-028: Macro REG_FILE_BYPASS_EN undefined: no forwarding; REQ-020 applies unchanged.
REQ-029: In both configurations, register 0 and the reset behaviour SHALL be identical.

Verification
REQ-030: Reset test: CLRN=0 asynchronously mid-cycle after writes to regs 5 and 31 -> Q1 and Q2 SHALL read 0 immediately, for N1=5 and N2=31.
REQ-031: Basic write/read: WE=1, ND=8, DI=0xDEADBEEF, edge; then N1=8 -> Q1 SHALL equal 0xDEADBEEF; reg 7 and reg 9 SHALL still read 0.
REQ-032: Register 0: WE=1, ND=0, DI=0xFFFFFFFF, edge; N1=0, N2=0 -> Q1 and Q2 SHALL equal 0, with and without the bypass macro.
REQ-033: Same-cycle hazard: reg3=0x11; WE=1, ND=3, DI=0x22, N1=3 before edge -> Q1 SHALL be 0x11 with the bypass macro undefined and 0x22 with it defined; after the edge Q1 SHALL be 0x22 in both.
REQ-034: WE gating: WE=0, ND=12, DI=0x55, edge -> reg12 SHALL read its prior value.
REQ-035: Sweep: write value i*0x01010101 to each register i=1..31, then read all pairs (i, 32-i) -> each port SHALL match its register's written value.
